// File: rtl/mips_mem_system.sv
// Unified word RAM plus MMIO (GPIO, 32-bit compare timer) behind the multicycle MIPS memory bus.
// Define MIPS_MEM_UART_EN to build the 8N1 UART transmitter at offset 0x10/0x14.
module mips_mem_system #(
   parameter int N            = 32,
   parameter int ADDR_W       = 10,
   parameter int GPIO_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      memoryAddress,
   input  logic [N-1:0]      memoryWriteData,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic [N-1:0]      memoryOutData,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq,
   output logic              uart_tx
);

   localparam logic [5:0] OFF_GPIO   = 6'h00;
   localparam logic [5:0] OFF_TCOUNT = 6'h01;
   localparam logic [5:0] OFF_TCMP   = 6'h02;
   localparam logic [5:0] OFF_TCTRL  = 6'h03;
   localparam logic [5:0] OFF_UDATA  = 6'h04;
   localparam logic [5:0] OFF_USTAT  = 6'h05;

   logic              mmio_sel_s;
   logic              ram_in_range_s;
   logic              ram_we_s;
   logic              mmio_we_s;
   logic [5:0]        mmio_off_s;
   logic [ADDR_W-1:0] ram_idx_s;
   logic [N-1:0]      mmio_rdata_s;
   logic              busy_s;
   logic [1:0]        addr_unused_s;

   logic [N-1:0]      mem_q [2**ADDR_W];

   logic [GPIO_W-1:0] gpio_q, gpio_d;
   logic [N-1:0]      tcount_q, tcount_d;
   logic [N-1:0]      tcmp_q, tcmp_d;
   logic              en_q, en_d;
   logic              irq_en_q, irq_en_d;
   logic              match_q, match_d;
   logic              irq_q;
   logic              match_set_s;
   logic              match_clr_s;

   assign addr_unused_s  = memoryAddress[1:0];
   assign mmio_sel_s     = (memoryAddress[N-1:16] == 16'hFFFF);
   assign mmio_off_s     = memoryAddress[7:2];
   assign ram_idx_s      = memoryAddress[ADDR_W+1:2];
   assign ram_in_range_s = (memoryAddress[N-1:ADDR_W+2] == {(N-ADDR_W-2){1'b0}});
   assign ram_we_s       = MemWrite && !mmio_sel_s && ram_in_range_s;
   assign mmio_we_s      = MemWrite && mmio_sel_s;

   // RAM storage: no reset, written on the edge that completes a store
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         mem_q[ram_idx_s] <= memoryWriteData;
      end
   end

   // Timer and GPIO next state; a pending match set beats a same-cycle write-1-to-clear
   always_comb begin
      gpio_d      = gpio_q;
      tcount_d    = en_q ? (tcount_q + 32'd1) : tcount_q;
      tcmp_d      = tcmp_q;
      en_d        = en_q;
      irq_en_d    = irq_en_q;
      match_clr_s = 1'b0;
      match_set_s = en_q && (tcount_q == tcmp_q);
      if (mmio_we_s) begin
         case (mmio_off_s)
            OFF_GPIO:   gpio_d   = memoryWriteData[GPIO_W-1:0];
            OFF_TCOUNT: tcount_d = memoryWriteData;
            OFF_TCMP:   tcmp_d   = memoryWriteData;
            OFF_TCTRL: begin
               en_d        = memoryWriteData[0];
               irq_en_d    = memoryWriteData[1];
               match_clr_s = memoryWriteData[2];
            end
            default:    gpio_d   = gpio_q;
         endcase
      end else begin
         gpio_d = gpio_q;
      end
      match_d = match_set_s ? 1'b1 : (match_clr_s ? 1'b0 : match_q);
   end

   // Timer and GPIO registers; irq is registered alongside MATCH/IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_q   <= {GPIO_W{1'b0}};
         tcount_q <= 32'h0000_0000;
         tcmp_q   <= 32'hFFFF_FFFF;
         en_q     <= 1'b0;
         irq_en_q <= 1'b0;
         match_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         gpio_q   <= gpio_d;
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         match_q  <= match_d;
         irq_q    <= match_d & irq_en_d;
      end
   end

   assign gpio_out = gpio_q;
   assign irq      = irq_q;

`ifdef MIPS_MEM_UART_EN
   typedef enum logic [1:0] {
      U_IDLE  = 2'd0,
      U_START = 2'd1,
      U_DATA  = 2'd2,
      U_STOP  = 2'd3
   } uart_state_e;

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_e      ustate_q, ustate_d;
   logic [CNT_W-1:0] ucnt_q, ucnt_d;
   logic [2:0]       ubit_q, ubit_d;
   logic [7:0]       ubyte_q, ubyte_d;
   logic             utx_q, utx_d;
   logic             ucnt_last_s;
   logic             udata_we_s;

   assign udata_we_s  = mmio_we_s && (mmio_off_s == OFF_UDATA);
   assign ucnt_last_s = (ucnt_q == CNT_LAST);

   // UART FSM next state; tx is derived from the next state so the line is a flop output
   always_comb begin
      ustate_d = ustate_q;
      ucnt_d   = ucnt_q;
      ubit_d   = ubit_q;
      ubyte_d  = ubyte_q;
      case (ustate_q)
         U_IDLE: begin
            if (udata_we_s) begin
               ustate_d = U_START;
               ubyte_d  = memoryWriteData[7:0];
               ucnt_d   = {CNT_W{1'b0}};
               ubit_d   = 3'd0;
            end else begin
               ustate_d = U_IDLE;
            end
         end
         U_START: begin
            if (ucnt_last_s) begin
               ustate_d = U_DATA;
               ucnt_d   = {CNT_W{1'b0}};
            end else begin
               ucnt_d   = ucnt_q + CNT_W'(1);
            end
         end
         U_DATA: begin
            if (ucnt_last_s) begin
               ucnt_d = {CNT_W{1'b0}};
               if (ubit_q == 3'd7) begin
                  ustate_d = U_STOP;
               end else begin
                  ubit_d   = ubit_q + 3'd1;
               end
            end else begin
               ucnt_d = ucnt_q + CNT_W'(1);
            end
         end
         U_STOP: begin
            if (ucnt_last_s) begin
               ustate_d = U_IDLE;
               ucnt_d   = {CNT_W{1'b0}};
            end else begin
               ucnt_d   = ucnt_q + CNT_W'(1);
            end
         end
         default: ustate_d = U_IDLE;
      endcase
      case (ustate_d)
         U_START: utx_d = 1'b0;
         U_DATA:  utx_d = ubyte_d[ubit_d];
         default: utx_d = 1'b1;
      endcase
   end

   // UART state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ustate_q <= U_IDLE;
         ucnt_q   <= {CNT_W{1'b0}};
         ubit_q   <= 3'd0;
         ubyte_q  <= 8'h00;
         utx_q    <= 1'b1;
      end else begin
         ustate_q <= ustate_d;
         ucnt_q   <= ucnt_d;
         ubit_q   <= ubit_d;
         ubyte_q  <= ubyte_d;
         utx_q    <= utx_d;
      end
   end

   assign busy_s  = (ustate_q != U_IDLE);
   assign uart_tx = utx_q;
`else
   logic [31:0] uart_cfg_unused_s;

   assign uart_cfg_unused_s = 32'(CLKS_PER_BIT);
   assign busy_s            = 1'b0;
   assign uart_tx           = 1'b1;
`endif

   // Read path: zero latency, returns pre-write contents when a store hits the same word
   always_comb begin
      case (mmio_off_s)
         OFF_GPIO:   mmio_rdata_s = {{(N-GPIO_W){1'b0}}, gpio_q};
         OFF_TCOUNT: mmio_rdata_s = tcount_q;
         OFF_TCMP:   mmio_rdata_s = tcmp_q;
         OFF_TCTRL:  mmio_rdata_s = {{(N-3){1'b0}}, match_q, irq_en_q, en_q};
         OFF_USTAT:  mmio_rdata_s = {{(N-1){1'b0}}, busy_s};
         default:    mmio_rdata_s = 32'h0000_0000;
      endcase
      if (!MemRead) begin
         memoryOutData = 32'h0000_0000;
      end else if (mmio_sel_s) begin
         memoryOutData = mmio_rdata_s;
      end else if (ram_in_range_s) begin
         memoryOutData = mem_q[ram_idx_s];
      end else begin
         memoryOutData = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_mips_mem_system.sv
// Scoreboard bench for mips_mem_system: per-cycle expectations from a transaction-level model.
module tb_mips_mem_system;

   localparam int C = 4;
`ifdef MIPS_MEM_UART_EN
   localparam bit UART_ON = 1'b1;
`else
   localparam bit UART_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic        rd, wr;
   logic [7:0]  gpio;
   logic        irq, tx;

   always #5 clk = ~clk;

   mips_mem_system #(.N(32), .ADDR_W(10), .GPIO_W(8), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst),
      .memoryAddress(addr), .memoryWriteData(wdata),
      .MemRead(rd), .MemWrite(wr),
      .memoryOutData(rdata), .gpio_out(gpio), .irq(irq), .uart_tx(tx)
   );

   typedef struct {
      logic [31:0] rdv;
      logic [7:0]  gpio;
      logic        irq;
      logic        tx;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   // reference model state
   logic [31:0] m_ram [int];
   logic [7:0]  m_gpio;
   logic [31:0] m_tcount, m_tcmp;
   logic        m_en, m_ie, m_match;
   bit          u_act;
   int          u_el;
   logic [7:0]  u_byte;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("rdata", rdata, mon_e.rdv);
         chk("gpio_out", {24'h0, gpio}, {24'h0, mon_e.gpio});
         chk("irq", {31'h0, irq}, {31'h0, mon_e.irq});
         chk("uart_tx", {31'h0, tx}, {31'h0, mon_e.tx});
      end
   end

   task automatic m_reset();
      m_gpio   = 8'h00;
      m_tcount = 32'h0;
      m_tcmp   = 32'hFFFF_FFFF;
      m_en     = 1'b0;
      m_ie     = 1'b0;
      m_match  = 1'b0;
      u_act    = 1'b0;
      u_el     = 0;
      u_byte   = 8'h00;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:16] == 16'hFFFF) begin
         case (a[7:2])
            6'd0:    return {24'h0, m_gpio};
            6'd1:    return m_tcount;
            6'd2:    return m_tcmp;
            6'd3:    return {29'h0, m_match, m_ie, m_en};
            6'd5:    return {31'h0, u_act};
            default: return 32'h0;
         endcase
      end
      if (a[31:12] != 20'h0) return 32'h0;
      if (m_ram.exists(int'(a[11:2]))) return m_ram[int'(a[11:2])];
      return 32'h0;
   endfunction

   function automatic logic m_tx();
      int b;
      if (!u_act) return 1'b1;
      b = u_el / C;
      if (b == 0) return 1'b0;
      if (b >= 9) return 1'b1;
      return u_byte[b-1];
   endfunction

   task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] n_cnt;
      logic        n_match, set, accept;
      set     = m_en && (m_tcount == m_tcmp);
      n_cnt   = m_en ? m_tcount + 32'd1 : m_tcount;
      n_match = m_match;
      accept  = 1'b0;
      if (w) begin
         if (a[31:16] == 16'hFFFF) begin
            case (a[7:2])
               6'd0: m_gpio = d[7:0];
               6'd1: n_cnt  = d;
               6'd2: m_tcmp = d;
               6'd3: begin
                  m_en = d[0];
                  m_ie = d[1];
                  if (d[2]) n_match = 1'b0;
               end
               6'd4: accept = UART_ON && !u_act;
               default: ;
            endcase
         end else if (a[31:12] == 20'h0) begin
            m_ram[int'(a[11:2])] = d;
         end
      end
      if (set) n_match = 1'b1;
      m_tcount = n_cnt;
      m_match  = n_match;
      if (u_act) begin
         u_el++;
         if (u_el == 10 * C) u_act = 1'b0;
      end
      if (accept) begin
         u_act  = 1'b1;
         u_el   = 0;
         u_byte = d[7:0];
      end
   endtask

   // one bus cycle, entered and left just after a rising edge
   task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      rd    = r;
      wr    = w;
      addr  = a;
      wdata = d;
      e.rdv  = r ? m_read(a) : 32'h0;
      e.gpio = m_gpio;
      e.irq  = m_match & m_ie;
      e.tx   = m_tx();
      exp_q.push_back(e);
      m_step(w, a, d);
      @(posedge clk);
      #1;
      rd = 1'b0;
      wr = 1'b0;
   endtask

   task automatic reset_mid();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_gpio_async", {24'h0, gpio}, 32'h0);
      chk("rst_irq_async", {31'h0, irq}, 32'h0);
      chk("rst_tx_async", {31'h0, tx}, 32'h1);
      @(posedge clk);
      #1;
      m_reset();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          idx, sel;
      logic [31:0] a, d;
      logic        r, w;
      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'hFFFF_0000 | (32'(i) << 2), 32'h0);

      // RAM preload and directed cases
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 32'(i) << 2, $urandom);
      cyc(1'b0, 1'b1, 32'h0000_0FFC, $urandom);
      cyc(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      cyc(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      cyc(1'b0, 1'b0, 32'h0000_0010, 32'h0);
      cyc(1'b0, 1'b1, 32'h0001_0010, 32'h1234_5678);
      cyc(1'b1, 1'b0, 32'h0001_0010, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0013, 32'h0);
      cyc(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
      cyc(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);

      // GPIO
      cyc(1'b0, 1'b1, 32'hFFFF_0000, 32'h1234_56A5);
      cyc(1'b1, 1'b0, 32'hFFFF_0000, 32'h0);

      // timer compare and interrupt
      cyc(1'b0, 1'b1, 32'hFFFF_0008, 32'd5);
      cyc(1'b0, 1'b1, 32'hFFFF_0004, 32'd0);
      cyc(1'b0, 1'b1, 32'hFFFF_000C, 32'd3);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
      cyc(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
      cyc(1'b0, 1'b1, 32'hFFFF_000C, 32'd4);
      cyc(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);

      // wrap and write-over-increment
      cyc(1'b0, 1'b1, 32'hFFFF_000C, 32'd1);
      cyc(1'b0, 1'b1, 32'hFFFF_0004, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
      cyc(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
      cyc(1'b0, 1'b1, 32'hFFFF_0004, 32'd100);
      cyc(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);

      // clear coinciding with a new match
      cyc(1'b0, 1'b1, 32'hFFFF_0008, 32'd50);
      cyc(1'b0, 1'b1, 32'hFFFF_000C, 32'd4);
      cyc(1'b0, 1'b1, 32'hFFFF_0004, 32'd48);
      cyc(1'b0, 1'b1, 32'hFFFF_000C, 32'd3);
      cyc(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
      cyc(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
      cyc(1'b1, 1'b1, 32'hFFFF_000C, 32'd7);
      cyc(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);

      // UART frame with an ignored second write
      cyc(1'b0, 1'b1, 32'hFFFF_0010, 32'h0000_0055);
      for (int i = 0; i < 45; i++) begin
         if (i == 10) cyc(1'b0, 1'b1, 32'hFFFF_0010, 32'h0000_00FF);
         else         cyc(1'b1, 1'b0, 32'hFFFF_0014, 32'h0);
      end
      cyc(1'b0, 1'b1, 32'hFFFF_0010, {24'h0, 8'($urandom)});
      for (int i = 0; i < 42; i++) cyc(1'b1, 1'b0, 32'hFFFF_0014, 32'h0);

      // asynchronous reset in the middle of activity
      cyc(1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_005A);
      cyc(1'b0, 1'b1, 32'hFFFF_0010, 32'h0000_003C);
      cyc(1'b1, 1'b0, 32'hFFFF_0014, 32'h0);
      reset_mid();
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'hFFFF_0000 | (32'(i) << 2), 32'h0);
      cyc(1'b1, 1'b0, 32'h0000_0010, 32'h0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4) begin
            idx = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 15);
            a   = (32'(idx) << 2) | ($urandom & 32'h3);
         end else if (sel == 4) begin
            a = ($urandom & 32'h7FFF_FFFF) | 32'h0000_1000;
         end else begin
            a = {16'hFFFF, 8'($urandom), 6'($urandom_range(0, 7)), 2'($urandom)};
         end
         d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 60));
         r = 1'($urandom_range(0, 1));
         w = ($urandom_range(0, 2) == 0);
         cyc(r, w, a, d);
      end
      cyc(1'b0, 1'b0, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
